divider_pool_arbiter: RTL and testbench

Allocates a pool of iterative dividers among the MulDiv issue lanes. Each issued div acquires one divider for its whole lifetime. The block tracks every divider through a reserve / process / wait-for-replay life cycle and returns it to the pool on release or pipeline flush. It sits between the MulDiv issue-queue select logic and the divider instances, replacing the fixed lane-to-divider binding with round-robin sharing.

---
 rtl/divider_pool_arbiter_pkg.sv | 19 +
 rtl/divider_pool_select.sv | 52 +++++
 rtl/divider_pool_arbiter.sv | 117 +++++++++++
 tb/tb_divider_pool_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/divider_pool_arbiter_pkg.sv
// Shared MulDiv types: divider life-cycle phase and the flush range helper.
package divider_pool_arbiter_pkg;

  typedef enum logic [1:0] {
    PH_FREE       = 2'd0,
    PH_RESERVED   = 2'd1,
    PH_PROCESSING = 2'd2,
    PH_WAITING    = 2'd3
  } divider_phase_e;

  // Active-list range [head, tail) with wrap; head == tail is an empty range.
  function automatic logic flush_range_hit(input logic [31:0] owner,
                                           input logic [31:0] head,
                                           input logic [31:0] tail);
    if (head <= tail) return (owner >= head) && (owner < tail);
    else              return (owner >= head) || (owner < tail);
  endfunction

endpackage

// File: rtl/divider_pool_select.sv
// Rotating-priority matcher: the k-th requesting lane (counted from rr_ptr_i)
// receives the k-th lowest-index free unit.
module divider_pool_select #(
  parameter int REQ_NUM  = 2,
  parameter int UNIT_NUM = 2,
  parameter int UW       = 1,
  parameter int RW       = 1
) (
  input  logic [REQ_NUM-1:0]          req_i,
  input  logic [UNIT_NUM-1:0]         free_i,
  input  logic                        block_i,
  input  logic [RW-1:0]               rr_ptr_i,
  output logic [REQ_NUM-1:0]          grant_o,
  output logic [REQ_NUM-1:0][UW-1:0]  unit_o,
  output logic                        any_o,
  output logic [RW-1:0]               rr_next_o
);

  // Walk lanes in priority order, consuming the lowest remaining free unit each time.
  always_comb begin : match
    logic [UNIT_NUM-1:0] avail;
    logic                found;
    int                  lane;
    int                  last;
    grant_o   = '0;
    unit_o    = '0;
    any_o     = 1'b0;
    avail     = free_i;
    last      = 0;
    found     = 1'b0;
    lane      = 0;
    for (int k = 0; k < REQ_NUM; k++) begin
      lane = int'(rr_ptr_i) + k;
      if (lane >= REQ_NUM) lane = lane - REQ_NUM;
      found = 1'b0;
      if (req_i[lane] && !block_i) begin
        for (int u = 0; u < UNIT_NUM; u++) begin
          if (!found && avail[u]) begin
            found         = 1'b1;
            avail[u]      = 1'b0;
            grant_o[lane] = 1'b1;
            unit_o[lane]  = UW'(u);
            any_o         = 1'b1;
            last          = lane;
          end
        end
      end
    end
    rr_next_o = (last + 1 >= REQ_NUM) ? '0 : RW'(last + 1);
  end

endmodule

// File: rtl/divider_pool_arbiter.sv
// Shares a pool of iterative dividers among MulDiv issue lanes and tracks
// each divider through reserve / process / wait-for-replay until release or flush.
module divider_pool_arbiter
  import divider_pool_arbiter_pkg::*;
#(
  parameter int REQ_NUM      = 2,
  parameter int UNIT_NUM     = 2,
  parameter int AL_PTR_WIDTH = 6,
  localparam int UW = (UNIT_NUM > 1) ? $clog2(UNIT_NUM) : 1,
  localparam int FW = $clog2(UNIT_NUM + 1),
  localparam int RW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [REQ_NUM-1:0]                    acqValid,
  input  logic [REQ_NUM-1:0][AL_PTR_WIDTH-1:0]  acqPtr,
  output logic [REQ_NUM-1:0]                    acqGrant,
  output logic [REQ_NUM-1:0][UW-1:0]            acqUnit,
  input  logic [UNIT_NUM-1:0]                   startValid,
  input  logic [UNIT_NUM-1:0]                   unitFinished,
  input  logic [UNIT_NUM-1:0]                   releaseValid,
  input  logic                                  flushValid,
  input  logic                                  flushAll,
  input  logic [AL_PTR_WIDTH-1:0]               flushHead,
  input  logic [AL_PTR_WIDTH-1:0]               flushTail,
  output logic [UNIT_NUM-1:0]                   unitRst,
  output logic [UNIT_NUM-1:0][1:0]              unitPhase,
  output logic [UNIT_NUM-1:0][AL_PTR_WIDTH-1:0] unitOwner,
  output logic [FW-1:0]                         freeCount
);

  divider_phase_e          phase_q [UNIT_NUM];
  logic [AL_PTR_WIDTH-1:0] owner_q [UNIT_NUM];
  logic [RW-1:0]           rr_q;
  logic [RW-1:0]           rr_d;
  logic                    any_grant;

  logic [UNIT_NUM-1:0]     free_mask;
  logic [UNIT_NUM-1:0]     flush_hit;
  logic [UNIT_NUM-1:0]     unit_grant;
  logic [AL_PTR_WIDTH-1:0] unit_ptr [UNIT_NUM];

  // Free mask, free count, flush decode and registered-state outputs.
  always_comb begin
    freeCount = '0;
    for (int u = 0; u < UNIT_NUM; u++) begin
      free_mask[u] = (phase_q[u] == PH_FREE);
      if (free_mask[u]) freeCount = freeCount + FW'(1);
      flush_hit[u] = flushValid && !free_mask[u] &&
                     (flushAll || flush_range_hit(32'(owner_q[u]), 32'(flushHead),
                                                  32'(flushTail)));
      unitPhase[u] = phase_q[u];
      unitOwner[u] = owner_q[u];
    end
    unitRst = flush_hit | {UNIT_NUM{rst}};
  end

  divider_pool_select #(
    .REQ_NUM (REQ_NUM),
    .UNIT_NUM(UNIT_NUM),
    .UW      (UW),
    .RW      (RW)
  ) u_select (
    .req_i    (acqValid),
    .free_i   (free_mask),
    .block_i  (flushValid | rst),
    .rr_ptr_i (rr_q),
    .grant_o  (acqGrant),
    .unit_o   (acqUnit),
    .any_o    (any_grant),
    .rr_next_o(rr_d)
  );

  // Map lane grants back onto the units they reserve.
  always_comb begin
    for (int u = 0; u < UNIT_NUM; u++) begin
      unit_grant[u] = 1'b0;
      unit_ptr[u]   = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
        if (acqGrant[i] && (acqUnit[i] == UW'(u))) begin
          unit_grant[u] = 1'b1;
          unit_ptr[u]   = acqPtr[i];
        end
      end
    end
  end

  // Per-unit life-cycle FSM and round-robin pointer; flush beats every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
      for (int u = 0; u < UNIT_NUM; u++) begin
        phase_q[u] <= PH_FREE;
        owner_q[u] <= '0;
      end
    end else begin
      if (any_grant) rr_q <= rr_d;
      for (int u = 0; u < UNIT_NUM; u++) begin
        if (flush_hit[u]) begin
          phase_q[u] <= PH_FREE;
        end else begin
          case (phase_q[u])
            PH_FREE:       if (unit_grant[u]) begin
                             phase_q[u] <= PH_RESERVED;
                             owner_q[u] <= unit_ptr[u];
                           end
            PH_RESERVED:   if (startValid[u])   phase_q[u] <= PH_PROCESSING;
            PH_PROCESSING: if (unitFinished[u]) phase_q[u] <= PH_WAITING;
            PH_WAITING:    if (releaseValid[u]) phase_q[u] <= PH_FREE;
            default:       phase_q[u] <= PH_FREE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_divider_pool_arbiter.sv
// Scoreboard bench for divider_pool_arbiter (REQ_NUM=2, UNIT_NUM=2, AL_PTR_WIDTH=6).
module tb_divider_pool_arbiter;

  logic            clk;
  logic            rst;
  logic [1:0]      acq_valid;
  logic [1:0][5:0] acq_ptr;
  logic [1:0]      acq_grant;
  logic [1:0][0:0] acq_unit;
  logic [1:0]      start_valid;
  logic [1:0]      unit_finished;
  logic [1:0]      release_valid;
  logic            flush_valid;
  logic            flush_all;
  logic [5:0]      flush_head;
  logic [5:0]      flush_tail;
  logic [1:0]      unit_rst;
  logic [1:0][1:0] unit_phase;
  logic [1:0][5:0] unit_owner;
  logic [1:0]      free_count;

  divider_pool_arbiter #(
    .REQ_NUM(2), .UNIT_NUM(2), .AL_PTR_WIDTH(6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .acqValid    (acq_valid),
    .acqPtr      (acq_ptr),
    .acqGrant    (acq_grant),
    .acqUnit     (acq_unit),
    .startValid  (start_valid),
    .unitFinished(unit_finished),
    .releaseValid(release_valid),
    .flushValid  (flush_valid),
    .flushAll    (flush_all),
    .flushHead   (flush_head),
    .flushTail   (flush_tail),
    .unitRst     (unit_rst),
    .unitPhase   (unit_phase),
    .unitOwner   (unit_owner),
    .freeCount   (free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_GNT = 0, S_U0 = 1, S_U1 = 2, S_PH0 = 3, S_PH1 = 4,
                 S_OW0 = 5, S_OW1 = 6, S_FC = 7, S_RST = 8;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_GNT:   return 32'(acq_grant);
      S_U0:    return 32'(acq_unit[0]);
      S_U1:    return 32'(acq_unit[1]);
      S_PH0:   return 32'(unit_phase[0]);
      S_PH1:   return 32'(unit_phase[1]);
      S_OW0:   return 32'(unit_owner[0]);
      S_OW1:   return 32'(unit_owner[1]);
      S_FC:    return 32'(free_count);
      S_RST:   return 32'(unit_rst);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic settle();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    acq_valid     = '0;
    acq_ptr       = '0;
    start_valid   = '0;
    unit_finished = '0;
    release_valid = '0;
    flush_valid   = 1'b0;
    flush_all     = 1'b0;
    flush_head    = '0;
    flush_tail    = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    next_cycle();
    next_cycle();
    // reset: all units held in reset, no grants even with requests
    next_cycle(); rst = 1'b1; acq_valid = 2'b11;
    expect_val("rst_unitrst", S_RST, 3); expect_val("rst_grant", S_GNT, 0);
    expect_val("rst_free", S_FC, 2); expect_val("rst_ph0", S_PH0, 0); settle();
    next_cycle(); rst = 1'b0;
    expect_val("post_rst_unitrst", S_RST, 0); expect_val("post_rst_free", S_FC, 2); settle();

    // single request on lane0
    next_cycle(); acq_valid = 2'b01; acq_ptr[0] = 6'd5;
    expect_val("t1_grant", S_GNT, 1); expect_val("t1_unit0", S_U0, 0); settle();
    next_cycle(); unit_finished = 2'b01;
    expect_val("t1_ph0", S_PH0, 1); expect_val("t1_own0", S_OW0, 5); expect_val("t1_free", S_FC, 1); settle();

    // full life cycle of unit0; finish while RESERVED is ignored
    next_cycle(); start_valid = 2'b01;
    expect_val("lc_ignore_fin", S_PH0, 1); settle();
    next_cycle();
    expect_val("lc_proc", S_PH0, 2); settle();
    for (int i = 0; i < 33; i++) next_cycle();
    next_cycle(); unit_finished = 2'b01;
    expect_val("lc_still_proc", S_PH0, 2); settle();
    next_cycle(); release_valid = 2'b01;
    expect_val("lc_wait", S_PH0, 3); settle();
    next_cycle();
    expect_val("lc_free", S_PH0, 0); expect_val("lc_free_cnt", S_FC, 2); settle();

    // both lanes, rrPtr=1: lane1 -> unit0, lane0 -> unit1
    next_cycle(); acq_valid = 2'b11; acq_ptr[0] = 6'd20; acq_ptr[1] = 6'd10;
    expect_val("rr_grant", S_GNT, 3); expect_val("rr_u1", S_U1, 0); expect_val("rr_u0", S_U0, 1); settle();
    next_cycle(); acq_valid = 2'b11;
    expect_val("rr_own0", S_OW0, 10); expect_val("rr_own1", S_OW1, 20);
    expect_val("rr_ph1", S_PH1, 1); expect_val("busy_free", S_FC, 0);
    expect_val("busy_grant", S_GNT, 0); settle();

    // unit1 release in t: no grant in t, grant in t+1
    next_cycle(); start_valid = 2'b10; settle();
    next_cycle(); unit_finished = 2'b10;
    expect_val("u1_proc", S_PH1, 2); settle();
    next_cycle(); release_valid = 2'b10; acq_valid = 2'b01; acq_ptr[0] = 6'd62;
    expect_val("u1_wait", S_PH1, 3); expect_val("rel_same_grant", S_GNT, 0); settle();
    next_cycle(); acq_valid = 2'b01; acq_ptr[0] = 6'd62;
    expect_val("rel_ph1", S_PH1, 0); expect_val("rel_free", S_FC, 1);
    expect_val("rel_next_grant", S_GNT, 1); expect_val("rel_next_unit", S_U0, 1); settle();
    next_cycle();
    expect_val("own62_ph", S_PH1, 1); expect_val("own62", S_OW1, 62); settle();

    // wrapped range [60,3): only owner 62 flushed, owner 10 kept
    next_cycle(); flush_valid = 1'b1; flush_head = 6'd60; flush_tail = 6'd3; acq_valid = 2'b11;
    expect_val("wrap_unitrst", S_RST, 2); expect_val("flush_grant", S_GNT, 0); settle();
    next_cycle(); flush_valid = 1'b1; flush_head = 6'd7; flush_tail = 6'd7;
    expect_val("wrap_ph1", S_PH1, 0); expect_val("wrap_ph0", S_PH0, 1); expect_val("wrap_free", S_FC, 1);
    expect_val("empty_unitrst", S_RST, 0); settle();
    next_cycle(); acq_valid = 2'b01; acq_ptr[0] = 6'd33;
    expect_val("empty_ph0", S_PH0, 1); expect_val("regrant", S_GNT, 1); expect_val("regrant_u", S_U0, 1); settle();
    next_cycle(); flush_valid = 1'b1; flush_all = 1'b1;
    expect_val("own33", S_OW1, 33); expect_val("all_unitrst", S_RST, 3); settle();
    next_cycle();
    expect_val("all_free", S_FC, 2); expect_val("all_ph0", S_PH0, 0); expect_val("all_ph1", S_PH1, 0); settle();

    // flush together with release and request
    next_cycle(); acq_valid = 2'b01; acq_ptr[0] = 6'd44;
    expect_val("ff_grant", S_GNT, 1); expect_val("ff_unit", S_U0, 0); settle();
    next_cycle(); start_valid = 2'b01;
    expect_val("ff_own", S_OW0, 44); settle();
    next_cycle(); unit_finished = 2'b01; settle();
    next_cycle(); release_valid = 2'b01; flush_valid = 1'b1; flush_head = 6'd0; flush_tail = 6'd50;
    acq_valid = 2'b01;
    expect_val("ff_wait", S_PH0, 3); expect_val("ff_nogrant", S_GNT, 0); expect_val("ff_unitrst", S_RST, 1); settle();
    next_cycle();
    expect_val("ff_ph0", S_PH0, 0); expect_val("ff_free", S_FC, 2); settle();
    next_cycle();
    expect_val("ff_no_double", S_FC, 2); settle();

    // reset mid-operation drops reservations and rrPtr
    next_cycle(); acq_valid = 2'b11; acq_ptr[0] = 6'd1; acq_ptr[1] = 6'd2;
    expect_val("mr_grant", S_GNT, 3); expect_val("mr_u1", S_U1, 0); expect_val("mr_u0", S_U0, 1); settle();
    next_cycle(); rst = 1'b1;
    expect_val("mr_busy", S_FC, 0); expect_val("mr_unitrst", S_RST, 3); settle();
    next_cycle(); rst = 1'b0; acq_valid = 2'b11;
    expect_val("mr_free", S_FC, 2); expect_val("mr_ph0", S_PH0, 0); expect_val("mr_own1", S_OW1, 0);
    expect_val("rr0_u0", S_U0, 0); expect_val("rr0_u1", S_U1, 1); settle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
